// File: rtl/seg7_pkg.sv
// Shared constants for the 8-digit scanned hex display.
// Holds the digit count and the gfedcba segment table.
package seg7_pkg;

  localparam int NUM_DIGITS = 8;

  localparam logic [6:0] SEG_OFF = 7'h00;

  // Active-high gfedcba patterns, entry 0 at the low end
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39,
    7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66,
    7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [6:0] hex_seg(input logic [3:0] nib);
    return SEG_TABLE[nib];
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-high gfedcba decoder.
// One instance serves the currently scanned digit.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = hex_seg(i_nib);
  end

endmodule

// File: rtl/seg7_scan_32.sv
// Frame-coherent 8-digit multiplexed hex display driver for a 32-bit word.
// Define SEG7_LEADING_ZERO_BLANK_EN to blank leading zero digits.
module seg7_scan_32
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV_W = 17,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_in,
  input  logic        load,
  input  logic [7:0]  dp_in,
  input  logic [7:0]  digit_en,
  output logic [7:0]  an,
  output logic [7:0]  seg,
  output logic        frame_done
);

  logic [SCAN_DIV_W-1:0] r_presc;
  logic [2:0]            r_idx;
  logic [31:0]           r_pending;
  logic [31:0]           r_shadow;
  logic                  r_pend_valid;
  logic [7:0]            r_an;
  logic [7:0]            r_seg;
  logic                  r_frame_done;

  logic                  w_tick;
  logic                  w_wrap;
  logic [3:0]            w_nib;
  logic [6:0]            w_seg7;
  logic [7:0]            w_blank;
  logic [7:0]            w_an_nxt;

  always_comb begin
    w_tick = &r_presc;
    w_wrap = w_tick & (r_idx == 3'd7);
    w_nib  = r_shadow[4*r_idx +: 4];
  end

  hex_to_seg7 u_dec (
    .i_nib (w_nib),
    .o_seg (w_seg7)
  );

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  // Walk down from the top digit while everything seen so far is zero
  always_comb begin
    logic w_zero_above;
    w_blank      = '0;
    w_zero_above = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      w_zero_above = w_zero_above & (r_shadow[4*k +: 4] == 4'h0);
      w_blank[k]   = w_zero_above & ~dp_in[k] & (k != 0);
    end
  end
`else
  always_comb begin
    w_blank = '0;
  end
`endif

  always_comb begin
    w_an_nxt = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      w_an_nxt[k] = (r_idx == 3'(k)) & digit_en[k] & ~w_blank[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc <= '0;
      r_idx   <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
      if (w_tick) r_idx <= r_idx + 3'd1;
    end
  end

  // A load on the wrap edge stays pending for the following frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending    <= '0;
      r_shadow     <= '0;
      r_pend_valid <= 1'b0;
    end else begin
      if (load) r_pending <= data_in;
      if (w_wrap) begin
        if (r_pend_valid) r_shadow <= r_pending;
        r_pend_valid <= load;
      end else if (load) begin
        r_pend_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_an         <= '0;
      r_seg        <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_an         <= w_an_nxt;
      r_seg        <= {dp_in[r_idx], w_seg7};
      r_frame_done <= w_wrap;
    end
  end

  always_comb begin
    an         = ACTIVE_LOW ? ~r_an  : r_an;
    seg        = ACTIVE_LOW ? ~r_seg : r_seg;
    frame_done = r_frame_done;
  end

endmodule

// File: tb/tb_seg7_scan_32.sv
// Self-checking bench for seg7_scan_32 (SCAN_DIV_W=2, ACTIVE_LOW=0).
module tb_seg7_scan_32;

  typedef struct {
    logic [7:0] an;
    logic [7:0] seg;
  } slot_t;

  typedef struct {
    logic [31:0] word;
    logic [7:0]  en;
    logic [7:0]  dp;
  } vec_t;

  localparam logic [6:0] TBL [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic        clk;
  logic        rst;
  logic [31:0] data_in;
  logic        load;
  logic [7:0]  dp_in;
  logic [7:0]  digit_en;
  logic [7:0]  an;
  logic [7:0]  seg;
  logic        frame_done;

  int n_vec;
  int n_bad;
  slot_t sb[$];
  vec_t  vecs[4];

  seg7_scan_32 #(
    .SCAN_DIV_W (2),
    .ACTIVE_LOW (1'b0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .load       (load),
    .dp_in      (dp_in),
    .digit_en   (digit_en),
    .an         (an),
    .seg        (seg),
    .frame_done (frame_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic slot_t exp_slot(input logic [31:0] w,
                                     input logic [7:0] en,
                                     input logic [7:0] dp,
                                     input int s);
    slot_t r;
    logic [3:0] nib;
    logic blank;
    nib   = w[4*s +: 4];
    blank = 1'b0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    blank = (s != 0) && !dp[s] && ((w >> (4*s)) == 32'h0);
`endif
    r.an  = (en[s] && !blank) ? 8'(1 << s) : 8'h00;
    r.seg = {dp[s], TBL[nib]};
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic push_frame(input logic [31:0] w, input logic [7:0] en,
                            input logic [7:0] dp);
    for (int s = 0; s < 8; s++) sb.push_back(exp_slot(w, en, dp, s));
  endtask

  task automatic do_load(input logic [31:0] w);
    data_in = w;
    load    = 1'b1;
    @(negedge clk);
    load    = 1'b0;
  endtask

  task automatic wait_fd();
    int n;
    n = 0;
    while (!frame_done && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("frame_done_timeout", 32'(frame_done), 32'd1);
  endtask

  task automatic check_frame();
    slot_t e;
    wait_fd();
    for (int s = 0; s < 8; s++) begin
      if (sb.size() == 0) begin
        chk("scoreboard_empty", 32'd0, 32'd1);
        e.an  = 8'hxx;
        e.seg = 8'hxx;
      end else begin
        e = sb.pop_front();
      end
      for (int j = 0; j < 4; j++) begin
        @(posedge clk);
        @(negedge clk);
        chk($sformatf("an_slot%0d", s), 32'(an), 32'(e.an));
        chk($sformatf("seg_slot%0d", s), 32'(seg), 32'(e.seg));
        chk("frame_done_pulse", 32'(frame_done),
            32'((s == 7) && (j == 3)));
      end
    end
  endtask

  initial begin
    slot_t e;
    vecs[0] = '{32'h01234567, 8'hFF, 8'h00};
    vecs[1] = '{32'hDEADBEEF, 8'h0F, 8'h10};
    vecs[2] = '{32'h89ABCDEF, 8'hFF, 8'hA5};
    vecs[3] = '{32'h00000A00, 8'hFF, 8'h20};
    n_vec    = 0;
    n_bad    = 0;
    rst      = 1'b0;
    load     = 1'b0;
    data_in  = '0;
    dp_in    = '0;
    digit_en = 8'hFF;

    #2 rst = 1'b1;
    #1;
    chk("reset_an", 32'(an), 32'h00);
    chk("reset_seg", 32'(seg), 32'h00);
    chk("reset_fd", 32'(frame_done), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int v = 0; v < 4; v++) begin
      digit_en = vecs[v].en;
      dp_in    = vecs[v].dp;
      do_load(vecs[v].word);
      push_frame(vecs[v].word, vecs[v].en, vecs[v].dp);
      check_frame();
    end

    // Load mid-frame: remainder of this frame keeps the old word
    digit_en = 8'hFF;
    dp_in    = 8'h00;
    repeat (20) @(negedge clk);
    e = exp_slot(32'h00000A00, 8'hFF, 8'h00, 4);
    chk("mid_old_an4", 32'(an), 32'(e.an));
    chk("mid_old_seg4", 32'(seg), 32'(e.seg));
    do_load(32'hDEADBEEF);
    e = exp_slot(32'h00000A00, 8'hFF, 8'h00, 5);
    chk("mid_old_an5", 32'(an), 32'(e.an));
    chk("mid_old_seg5", 32'(seg), 32'(e.seg));
    push_frame(32'hDEADBEEF, 8'hFF, 8'h00);
    check_frame();

    // Load on the wrap edge is deferred by one whole frame
    repeat (31) @(negedge clk);
    chk("pre_wrap_fd", 32'(frame_done), 32'd0);
    do_load(32'h12345678);
    push_frame(32'hDEADBEEF, 8'hFF, 8'h00);
    push_frame(32'h12345678, 8'hFF, 8'h00);
    check_frame();
    check_frame();

    // Reset in slot 5 aborts the scan and clears the shadow word
    repeat (22) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_an", 32'(an), 32'h00);
    chk("midrst_seg", 32'(seg), 32'h00);
    chk("midrst_fd", 32'(frame_done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int s = 0; s < 2; s++) begin
      e = exp_slot(32'h0, 8'hFF, 8'h00, s);
      for (int j = 0; j < 4; j++) begin
        @(posedge clk);
        @(negedge clk);
        chk($sformatf("post_rst_an%0d", s), 32'(an), 32'(e.an));
        chk($sformatf("post_rst_seg%0d", s), 32'(seg), 32'(e.seg));
      end
    end

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
